// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts pattern[len-1:0] out MSB first, repeating
// reps times with GAP idle cycles between repetitions; one-cycle done pulse at the end.
module seq_pattern_tx #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 4,
  parameter  int GAP   = 2,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] len;
  } job_t;

  state_t           state_q, state_d;
  job_t             job_q, job_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_clamped;
  logic [WIDTH-1:0] shifted;
  logic             zero_job;

  assign load_ready = (state_q == S_IDLE);
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    gap_cnt_d  = gap_cnt_q;
    zero_job   = 1'b0;
    len_clamped = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    case (state_q)
      S_IDLE: begin
        if (load_valid && !abort) begin
          job_d.pat = pattern;
          job_d.len = len_clamped;
          if (reps == '0) begin
            zero_job = 1'b1;
          end else begin
            state_d    = S_SEND;
            bit_idx_d  = len_clamped - LEN_W'(1);
            rep_left_d = reps;
          end
        end
      end
      S_SEND: begin
        if (bit_idx_q == '0) begin
          if (rep_left_q == CNT_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            rep_left_d = rep_left_q - CNT_W'(1);
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = GW'(GAP - 1);
            end else begin
              bit_idx_d = job_q.len - LEN_W'(1);
            end
          end
        end else begin
          bit_idx_d = bit_idx_q - LEN_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = S_SEND;
          bit_idx_d = job_q.len - LEN_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort only cancels a running job; in IDLE it merely blocks the handshake.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;

    // Outputs are registered copies of what the next state will present.
    shifted     = job_d.pat >> bit_idx_d;
    out_valid_d = (state_d == S_SEND);
    out_d       = out_valid_d & shifted[0];
    busy_d      = (state_d != S_IDLE);
    done_d      = zero_job |
                  (out_valid_d && bit_idx_d == '0 && rep_left_d == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      job_q       <= '0;
      bit_idx_q   <= '0;
      rep_left_q  <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      bit_idx_q   <= bit_idx_d;
      rep_left_q  <= rep_left_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: GAP=2 and GAP=0 instances checked cycle by cycle
// against a sequence model built from pattern/len/reps.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv_a = 1'b0, lv_b = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       abort = 1'b0;
  logic       lr_a, o_a, ov_a, b_a, d_a;
  logic       lr_b, o_b, ov_b, b_b, d_b;

  int total = 0;
  int bad   = 0;

  bit exp_o[$], exp_v[$], exp_b[$], exp_d[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a),
    .pattern(pattern), .len(len), .reps(reps), .abort(abort),
    .out(o_a), .out_valid(ov_a), .busy(b_a), .done(d_a));

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b),
    .pattern(pattern), .len(len), .reps(reps), .abort(abort),
    .out(o_b), .out_valid(ov_b), .busy(b_b), .done(d_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic o, output logic v,
                        output logic b, output logic d, output logic r);
    o = sel ? o_b : o_a;  v = sel ? ov_b : ov_a;
    b = sel ? b_b : b_a;  d = sel ? d_b : d_a;
    r = sel ? lr_b : lr_a;
  endtask

  // Expected per-cycle stream from T+1 on: rep bodies MSB first, gap zeros between.
  function automatic void build(input logic [7:0] p, input int l, input int r, input int gap);
    int eff;
    exp_o.delete(); exp_v.delete(); exp_b.delete(); exp_d.delete();
    eff = (l == 0 || l > 8) ? 8 : l;
    if (r == 0) begin
      exp_o.push_back(0); exp_v.push_back(0); exp_b.push_back(0); exp_d.push_back(1);
      return;
    end
    for (int k = 0; k < r; k++) begin
      for (int i = eff - 1; i >= 0; i--) begin
        exp_o.push_back(p[i]); exp_v.push_back(1); exp_b.push_back(1);
        exp_d.push_back(k == r - 1 && i == 0);
      end
      if (k < r - 1)
        for (int g = 0; g < gap; g++) begin
          exp_o.push_back(0); exp_v.push_back(0); exp_b.push_back(1); exp_d.push_back(0);
        end
    end
  endfunction

  // Handshake at next posedge; returns the number of 101 windows seen on out.
  task automatic run_job(input bit sel, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input string tag, output int hits);
    logic o, v, b, d, rd;
    logic [2:0] win;
    int nv;
    hits = 0; win = '0; nv = 0;
    build(p, int'(l), int'(r), sel ? 0 : 2);
    @(negedge clk);
    pattern = p; len = l; reps = r;
    if (sel) lv_b = 1'b1; else lv_a = 1'b1;
    sample(sel, o, v, b, d, rd);
    chk({tag, ".ready"}, 32'(rd), 32'd1);
    @(posedge clk); #1;
    lv_a = 1'b0; lv_b = 1'b0;
    pattern = ~p; len = 4'd1; reps = 4'd1;  // must be ignored while busy
    for (int k = 0; k < exp_o.size(); k++) begin
      @(negedge clk);
      sample(sel, o, v, b, d, rd);
      chk($sformatf("%s.c%0d", tag, k), {28'd0, o, v, b, d}, {28'd0, exp_o[k], exp_v[k], exp_b[k], exp_d[k]});
      if (v) begin
        win = {win[1:0], o}; nv++;
        if (nv >= 3 && win == 3'b101) hits++;
      end else begin
        nv = 0;
      end
    end
    @(negedge clk);
    sample(sel, o, v, b, d, rd);
    chk({tag, ".after"}, {27'd0, o, v, b, d, rd}, 32'b00001);
  endtask

  initial begin
    int hits;
    logic o, v, b, d, rd;
    // reset state, held asynchronously
    #2;
    sample(0, o, v, b, d, rd);
    chk("rst.a", {27'd0, o, v, b, d, rd}, 32'b00001);
    sample(1, o, v, b, d, rd);
    chk("rst.b", {27'd0, o, v, b, d, rd}, 32'b00001);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle.a", {27'd0, o_a, ov_a, b_a, d_a, lr_a}, 32'b00001);

    run_job(0, 8'b0000_0101, 4'd3, 4'd1, "det101", hits);
    chk("det101.hits", 32'(hits), 32'd1);
    run_job(0, 8'b0000_1100, 4'd4, 4'd3, "gap2", hits);
    run_job(1, 8'b0000_0010, 4'd2, 4'd4, "gap0", hits);
    run_job(0, 8'hA5, 4'd0, 4'd1, "len0", hits);
    run_job(0, 8'h3C, 4'd0, 4'd0, "reps0", hits);
    run_job(1, 8'h01, 4'd1, 4'd3, "len1", hits);
    run_job(0, 8'h5A, 4'd12, 4'd2, "lenbig", hits);

    // abort on the 3rd bit, then an immediate new job
    build(8'hFF, 8, 2, 2);
    @(negedge clk);
    pattern = 8'hFF; len = 4'd8; reps = 4'd2; lv_a = 1'b1;
    @(posedge clk); #1 lv_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort.c%0d", k), {29'd0, o_a, ov_a, d_a}, 32'b110);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort.drop", {27'd0, o_a, ov_a, b_a, d_a, lr_a}, 32'b00001);
    // abort with load_valid in IDLE: nothing captured
    abort = 1'b1; lv_a = 1'b1;
    @(posedge clk); #1 abort = 1'b0; lv_a = 1'b0;
    @(negedge clk);
    chk("abort.idle", {27'd0, o_a, ov_a, b_a, d_a, lr_a}, 32'b00001);
    run_job(0, 8'b1001_0110, 4'd8, 4'd1, "post_abort", hits);

    // reset mid-job
    @(negedge clk);
    pattern = 8'b1011_0011; len = 4'd8; reps = 4'd2; lv_a = 1'b1;
    @(posedge clk); #1 lv_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.pre", {30'd0, ov_a, b_a}, 32'b11);
    #1 rst = 1'b1; #1;
    chk("midrst.now", {27'd0, o_a, ov_a, b_a, d_a, lr_a}, 32'b00001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("midrst.quiet", {28'd0, ov_a, b_a, d_a, lr_a}, 32'b0001);
    end

    // randomized jobs on both builds
    for (int n = 0; n < 24; n++) begin
      run_job(n[0], 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              $sformatf("rnd%0d", n), hits);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
